custom_axi_ip_regs: RTL and testbench

AXI4-Lite slave register file sitting directly upstream of the `custom_axi_ip` datapath core. It turns bus writes into the core's input word and a one-cycle start pulse. It captures the core's result and status into software-readable registers, and counts completed operations. One outstanding write and one outstanding read are supported; there is no interrupt output.

---
 rtl/custom_axi_ip_regs.sv | 238 +++++++++++++++++++++++
 tb/tb_custom_axi_ip_regs.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_ip_regs.sv
// AXI4-Lite register file in front of the custom_axi_ip core: turns bus
// writes into the core's input word and start pulse, captures the core's
// result and status, and counts completed operations.
module custom_axi_ip_regs #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   ipreg_data_o,
  output logic                    enable_o,
  input  logic [DATA_WIDTH-1:0]   ipreg_data_i,
  input  logic [1:0]              status_i
);

  // Core status encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  // Register word indices (addr[4:2])
  localparam logic [2:0] R_CTRL     = 3'd0;
  localparam logic [2:0] R_DATA_IN  = 3'd1;
  localparam logic [2:0] R_DATA_OUT = 3'd2;
  localparam logic [2:0] R_STATUS   = 3'd3;
  localparam logic [2:0] R_DONE_CNT = 3'd4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                    aw_hold_reg;
  logic [ADDR_WIDTH-1:0]   aw_addr_reg;
  logic                    w_hold_reg;
  logic [DATA_WIDTH-1:0]   w_data_reg;
  logic [DATA_WIDTH/8-1:0] w_strb_reg;
  logic                    bvalid_reg;
  logic [1:0]              bresp_reg;
  logic                    rvalid_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [1:0]              rresp_reg;
  logic                    enable_reg;
  logic [DATA_WIDTH-1:0]   data_in_reg;
  logic [DATA_WIDTH-1:0]   data_in_next;
  logic [DATA_WIDTH-1:0]   data_out_reg;
  logic [1:0]              status_q_reg;
  logic                    done_sticky_reg;
  logic                    err_sticky_reg;
  logic                    start_err_reg;
  logic [31:0]             done_count_reg;
  logic [31:0]             done_count_next;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH/8-1:0] wr_strb;
  logic                    wr_hit, rd_hit;
  logic [2:0]              wr_sel, rd_sel;
  logic                    wr_data_in, wr_status, wr_done_cnt, start_req, w1c;
  logic                    done_entry, err_entry;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [1:0]              rd_resp;
  logic                    unused_bits;

  // Readies are held low through reset and while a response is outstanding
  assign s_axi_awready = !rst_i && !aw_hold_reg && !bvalid_reg;
  assign s_axi_wready  = !rst_i && !w_hold_reg && !bvalid_reg;
  assign s_axi_arready = !rst_i && !rvalid_reg;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // A write commits once both halves are present (held or arriving now)
  assign commit  = (aw_hold_reg || aw_hs) && (w_hold_reg || w_hs) && !bvalid_reg;
  assign wr_addr = aw_hold_reg ? aw_addr_reg : s_axi_awaddr;
  assign wr_data = w_hold_reg ? w_data_reg : s_axi_wdata;
  assign wr_strb = w_hold_reg ? w_strb_reg : s_axi_wstrb;

  // Only word offsets 0x00..0x10 with clear upper bits are mapped
  assign wr_sel = wr_addr[4:2];
  assign rd_sel = s_axi_araddr[4:2];
  assign wr_hit = (wr_addr[ADDR_WIDTH-1:5] == '0) && (wr_sel <= R_DONE_CNT);
  assign rd_hit = (s_axi_araddr[ADDR_WIDTH-1:5] == '0) && (rd_sel <= R_DONE_CNT);

  assign wr_data_in  = commit && wr_hit && (wr_sel == R_DATA_IN);
  assign wr_status   = commit && wr_hit && (wr_sel == R_STATUS);
  assign wr_done_cnt = commit && wr_hit && (wr_sel == R_DONE_CNT);
  assign start_req   = commit && wr_hit && (wr_sel == R_CTRL) && wr_strb[0] && wr_data[0];
  assign w1c         = wr_status && wr_strb[1];

  assign done_entry = (status_i == ST_DONE) && (status_q_reg != ST_DONE);
  assign err_entry  = (status_i == ST_ERROR) && (status_q_reg != ST_ERROR);

  // Byte lanes below the word offset carry no decode information
  assign unused_bits = &{1'b0, wr_addr[1:0], s_axi_araddr[1:0]};

  // Byte-strobed update of DATA_IN
  generate
    for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_data_in
      assign data_in_next[gi*8 +: 8] = (wr_data_in && wr_strb[gi]) ?
                                       wr_data[gi*8 +: 8] : data_in_reg[gi*8 +: 8];
    end
  endgenerate

  // DONE_COUNT: a clear colliding with an increment leaves 1
  always_comb begin
    done_count_next = done_count_reg;
    if (wr_done_cnt) begin
      done_count_next = done_entry ? 32'd1 : 32'd0;
    end else if (done_entry) begin
      done_count_next = done_count_reg + 32'd1;
    end
  end

  // Read mux, sampled at the AR handshake (pre-write values)
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    if (!rd_hit) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (rd_sel)
        R_DATA_IN:  rd_word = data_in_reg;
        R_DATA_OUT: rd_word = data_out_reg;
        R_STATUS:   rd_word = {21'b0, start_err_reg, err_sticky_reg, done_sticky_reg,
                               6'b0, status_i};
        R_DONE_CNT: rd_word = done_count_reg;
        default:    rd_word = '0;
      endcase
    end
  end

  // Channel state, registers and sticky bits
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      aw_hold_reg     <= 1'b0;
      aw_addr_reg     <= '0;
      w_hold_reg      <= 1'b0;
      w_data_reg      <= '0;
      w_strb_reg      <= '0;
      bvalid_reg      <= 1'b0;
      bresp_reg       <= RESP_OKAY;
      rvalid_reg      <= 1'b0;
      rdata_reg       <= '0;
      rresp_reg       <= RESP_OKAY;
      enable_reg      <= 1'b0;
      data_in_reg     <= '0;
      data_out_reg    <= '0;
      status_q_reg    <= ST_IDLE;
      done_sticky_reg <= 1'b0;
      err_sticky_reg  <= 1'b0;
      start_err_reg   <= 1'b0;
      done_count_reg  <= '0;
    end else begin
      if (commit) begin
        aw_hold_reg <= 1'b0;
      end else if (aw_hs) begin
        aw_hold_reg <= 1'b1;
        aw_addr_reg <= s_axi_awaddr;
      end

      if (commit) begin
        w_hold_reg <= 1'b0;
      end else if (w_hs) begin
        w_hold_reg <= 1'b1;
        w_data_reg <= s_axi_wdata;
        w_strb_reg <= s_axi_wstrb;
      end

      if (commit) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_reg && s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end

      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_word;
        rresp_reg  <= rd_resp;
      end else if (rvalid_reg && s_axi_rready) begin
        rvalid_reg <= 1'b0;
      end

      enable_reg   <= start_req && (status_i == ST_IDLE);
      data_in_reg  <= data_in_next;
      status_q_reg <= status_i;
      if (status_i == ST_DONE) begin
        data_out_reg <= ipreg_data_i;
      end

      // Sticky sets take priority over a same-cycle W1C
      if (done_entry) begin
        done_sticky_reg <= 1'b1;
      end else if (w1c && wr_data[8]) begin
        done_sticky_reg <= 1'b0;
      end
      if (err_entry) begin
        err_sticky_reg <= 1'b1;
      end else if (w1c && wr_data[9]) begin
        err_sticky_reg <= 1'b0;
      end
      if (start_req && (status_i != ST_IDLE)) begin
        start_err_reg <= 1'b1;
      end else if (w1c && wr_data[10]) begin
        start_err_reg <= 1'b0;
      end

      done_count_reg <= done_count_next;
    end
  end

  assign s_axi_bvalid = bvalid_reg;
  assign s_axi_bresp  = bresp_reg;
  assign s_axi_rvalid = rvalid_reg;
  assign s_axi_rdata  = rdata_reg;
  assign s_axi_rresp  = rresp_reg;
  assign ipreg_data_o = data_in_reg;
  assign enable_o     = enable_reg;

endmodule

// File: tb/tb_custom_axi_ip_regs.sv
// Directed testbench for custom_axi_ip_regs: one task per feature, inline checks.
module tb_custom_axi_ip_regs;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b0;
  logic [7:0]  s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b0;
  logic [31:0] ipreg_data_o;
  logic        enable_o;
  logic [31:0] ipreg_data_i = '0;
  logic [1:0]  status_i = 2'd0;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  bit en_prev = 1'b0;
  bit en_double = 1'b0;

  custom_axi_ip_regs #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .ipreg_data_o(ipreg_data_o), .enable_o(enable_o),
    .ipreg_data_i(ipreg_data_i), .status_i(status_i)
  );

  always #5 clk_i = ~clk_i;

  // Count enable pulses and flag any two-cycle-long pulse
  always @(negedge clk_i) begin
    if (enable_o) en_cnt++;
    if (enable_o && en_prev) en_double = 1'b1;
    en_prev = enable_o;
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_i);
    #1;
  endtask

  // AW and W presented together; optionally changes status_i in the commit cycle
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input bit chg, input logic [1:0] st,
                          output logic [1:0] resp, output logic en_b);
    int n;
    bit aw_go, w_go;
    @(posedge clk_i); #1;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    if (chg) status_i = st;
    n = 0;
    while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
      @(negedge clk_i);
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go = s_axi_wvalid && s_axi_wready;
      @(posedge clk_i); #1;
      if (aw_go) s_axi_awvalid = 1'b0;
      if (w_go) s_axi_wvalid = 1'b0;
      n++;
    end
    total++;
    if (s_axi_awvalid || s_axi_wvalid) begin
      bad++;
      $display("FAIL wr_accept addr=%h: got not accepted, required accepted", a);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    end
    s_axi_bready = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!s_axi_bvalid && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    total++;
    if (!s_axi_bvalid) begin
      bad++;
      $display("FAIL wr_bvalid addr=%h: got no bvalid, required bvalid", a);
    end
    resp = s_axi_bresp;
    en_b = enable_o;
    @(posedge clk_i); #1;
    s_axi_bready = 1'b0;
    $display("write addr=%h data=%h strb=%h bresp=%0d", a, d, s, resp);
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    @(posedge clk_i); #1;
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!s_axi_arready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    @(posedge clk_i); #1;
    s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b1;
    n = 0;
    @(negedge clk_i);
    while (!s_axi_rvalid && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    total++;
    if (!s_axi_rvalid) begin
      bad++;
      $display("FAIL rd_rvalid addr=%h: got no rvalid, required rvalid", a);
    end
    d = s_axi_rdata;
    r = s_axi_rresp;
    @(posedge clk_i); #1;
    s_axi_rready = 1'b0;
    $display("read  addr=%h data=%h rresp=%0d", a, d, r);
  endtask

  task automatic test_reset();
    cycles(3);
    @(negedge clk_i);
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, enable_o} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, enable_o});
    end
    total++;
    if ({s_axi_bresp, s_axi_rresp, s_axi_rdata, ipreg_data_o} !== 68'h0) begin
      bad++;
      $display("FAIL reset_data: got %h required 0", {s_axi_bresp, s_axi_rresp, s_axi_rdata, ipreg_data_o});
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    total++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
      bad++;
      $display("FAIL reset_ready_after: got %b required 111", {s_axi_awready, s_axi_wready, s_axi_arready});
    end
    $display("reset released");
  endtask

  task automatic test_basic_write();
    logic [1:0] resp;
    logic en_b;
    logic [31:0] d;
    int en0;
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 1'b0, 2'd0, resp, en_b);
    total++;
    if (resp !== 2'b00) begin bad++; $display("FAIL basic_bresp: got %0d required 0", resp); end
    total++;
    if (ipreg_data_o !== 32'hDEADBEEF) begin
      bad++; $display("FAIL basic_ipreg: got %h required deadbeef", ipreg_data_o);
    end
    do_read(8'h04, d, resp);
    total++;
    if (d !== 32'hDEADBEEF || resp !== 2'b00) begin
      bad++; $display("FAIL basic_readback: got %h/%0d required deadbeef/0", d, resp);
    end
    en0 = en_cnt;
    do_write(8'h00, 32'h1, 4'hF, 1'b0, 2'd0, resp, en_b);
    cycles(3);
    total++;
    if (en_b !== 1'b1) begin bad++; $display("FAIL start_with_b: got %b required 1", en_b); end
    total++;
    if (en_cnt - en0 !== 1) begin bad++; $display("FAIL start_pulses: got %0d required 1", en_cnt - en0); end
    do_read(8'h00, d, resp);
    total++;
    if (d !== 32'h0 || resp !== 2'b00) begin bad++; $display("FAIL ctrl_read: got %h/%0d required 0/0", d, resp); end
  endtask

  task automatic test_split();
    logic [1:0] resp;
    logic en_b;
    do_write(8'h04, 32'h11223344, 4'hF, 1'b0, 2'd0, resp, en_b);
    s_axi_wdata = 32'h0000AB00; s_axi_wstrb = 4'h2; s_axi_wvalid = 1'b1;
    @(negedge clk_i);
    total++;
    if (s_axi_wready !== 1'b1) begin bad++; $display("FAIL split_wready: got %b required 1", s_axi_wready); end
    @(posedge clk_i); #1;
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      total++;
      if (s_axi_bvalid !== 1'b0 || ipreg_data_o !== 32'h11223344 || s_axi_wready !== 1'b0) begin
        bad++;
        $display("FAIL split_wait%0d: got bvalid=%b data=%h wready=%b required 0/11223344/0",
                 i, s_axi_bvalid, ipreg_data_o, s_axi_wready);
      end
      @(posedge clk_i); #1;
    end
    s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
    @(negedge clk_i);
    total++;
    if (s_axi_awready !== 1'b1) begin bad++; $display("FAIL split_awready: got %b required 1", s_axi_awready); end
    @(posedge clk_i); #1;
    s_axi_awvalid = 1'b0;
    s_axi_bready = 1'b1;
    @(negedge clk_i);
    total++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || ipreg_data_o !== 32'h1122AB44) begin
      bad++;
      $display("FAIL split_commit: got bvalid=%b bresp=%0d data=%h required 1/0/1122ab44",
               s_axi_bvalid, s_axi_bresp, ipreg_data_o);
    end
    @(posedge clk_i); #1;
    s_axi_bready = 1'b0;
    $display("split write data=%h", ipreg_data_o);
  endtask

  task automatic test_completion();
    logic [1:0] resp;
    logic en_b;
    logic [31:0] d;
    status_i = 2'd1;
    cycles(1);
    status_i = 2'd2; ipreg_data_i = 32'h55;
    cycles(2);
    do_read(8'h08, d, resp);
    total++;
    if (d !== 32'h55) begin bad++; $display("FAIL done_data_out: got %h required 55", d); end
    do_read(8'h10, d, resp);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL done_count_once: got %h required 1", d); end
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h102) begin bad++; $display("FAIL done_status: got %h required 102", d); end
    status_i = 2'd0;
    cycles(1);
    do_write(8'h0C, 32'h100, 4'hF, 1'b0, 2'd0, resp, en_b);
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL done_w1c: got %h required 0", d); end
  endtask

  task automatic test_start_err();
    logic [1:0] resp;
    logic en_b;
    logic [31:0] d;
    int en0;
    status_i = 2'd1;
    cycles(1);
    en0 = en_cnt;
    do_write(8'h00, 32'h1, 4'hF, 1'b0, 2'd0, resp, en_b);
    cycles(2);
    total++;
    if (en_cnt !== en0 || resp !== 2'b00) begin
      bad++; $display("FAIL start_err_nopulse: got pulses=%0d resp=%0d required 0/0", en_cnt - en0, resp);
    end
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h401) begin bad++; $display("FAIL start_err_set: got %h required 401", d); end
    do_write(8'h0C, 32'h400, 4'h1, 1'b0, 2'd0, resp, en_b);
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h401) begin bad++; $display("FAIL w1c_needs_strb1: got %h required 401", d); end
    do_write(8'h0C, 32'h400, 4'h2, 1'b0, 2'd0, resp, en_b);
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h001) begin bad++; $display("FAIL start_err_w1c: got %h required 1", d); end
    status_i = 2'd3;
    cycles(1);
    status_i = 2'd0;
    cycles(1);
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h200) begin bad++; $display("FAIL err_sticky: got %h required 200", d); end
    do_write(8'h0C, 32'h200, 4'h2, 1'b0, 2'd0, resp, en_b);
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL err_w1c: got %h required 0", d); end
  endtask

  task automatic test_collisions();
    logic [1:0] resp;
    logic en_b;
    logic [31:0] d;
    // W1C of DONE_STICKY in the same cycle as a DONE entry
    do_write(8'h0C, 32'h100, 4'h2, 1'b1, 2'd2, resp, en_b);
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h102) begin bad++; $display("FAIL sticky_set_wins: got %h required 102", d); end
    do_read(8'h10, d, resp);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL count_second: got %h required 2", d); end
    status_i = 2'd0;
    cycles(2);
    // DONE_COUNT clear in the same cycle as a DONE entry
    do_write(8'h10, 32'h0, 4'hF, 1'b1, 2'd2, resp, en_b);
    do_read(8'h10, d, resp);
    total++;
    if (d !== 32'h1) begin bad++; $display("FAIL count_clr_inc: got %h required 1", d); end
    status_i = 2'd0;
    cycles(2);
  endtask

  task automatic test_unmapped();
    logic [1:0] resp;
    logic en_b;
    logic [31:0] d;
    s_axi_araddr = 8'h18; s_axi_arvalid = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      total++;
      if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h0 || s_axi_rresp !== 2'b10 || s_axi_arready !== 1'b0) begin
        bad++;
        $display("FAIL unmapped_hold%0d: got rvalid=%b rdata=%h rresp=%0d arready=%b required 1/0/2/0",
                 i, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_arready);
      end
      @(posedge clk_i); #1;
    end
    s_axi_rready = 1'b1;
    @(posedge clk_i); #1;
    s_axi_rready = 1'b0;
    @(negedge clk_i);
    total++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      bad++; $display("FAIL unmapped_release: got rvalid=%b arready=%b required 0/1", s_axi_rvalid, s_axi_arready);
    end
    $display("read  addr=18 backpressure done");
    do_read(8'h1C, d, resp);
    total++;
    if (d !== 32'h0 || resp !== 2'b10) begin bad++; $display("FAIL unmapped_1c: got %h/%0d required 0/2", d, resp); end
    do_write(8'h14, 32'hFFFFFFFF, 4'hF, 1'b0, 2'd0, resp, en_b);
    total++;
    if (resp !== 2'b10) begin bad++; $display("FAIL unmapped_w14: got %0d required 2", resp); end
    do_write(8'h24, 32'hFFFFFFFF, 4'hF, 1'b0, 2'd0, resp, en_b);
    total++;
    if (resp !== 2'b10) begin bad++; $display("FAIL unmapped_w24: got %0d required 2", resp); end
    do_write(8'h08, 32'hFFFFFFFF, 4'hF, 1'b0, 2'd0, resp, en_b);
    total++;
    if (resp !== 2'b00) begin bad++; $display("FAIL ro_write_okay: got %0d required 0", resp); end
    do_read(8'h04, d, resp);
    total++;
    if (d !== 32'h1122AB44) begin bad++; $display("FAIL unmapped_nochange: got %h required 1122ab44", d); end
    do_read(8'h08, d, resp);
    total++;
    if (d !== 32'h55) begin bad++; $display("FAIL ro_nochange: got %h required 55", d); end
  endtask

  task automatic test_wrap();
    logic [1:0] resp;
    logic [31:0] d;
    @(posedge clk_i); #1;
    force dut.done_count_reg = 32'hFFFFFFFF;
    @(posedge clk_i); #1;
    release dut.done_count_reg;
    do_read(8'h10, d, resp);
    total++;
    if (d !== 32'hFFFFFFFF) begin bad++; $display("FAIL wrap_preload: got %h required ffffffff", d); end
    status_i = 2'd2;
    cycles(1);
    status_i = 2'd0;
    cycles(1);
    do_read(8'h10, d, resp);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wrap_zero: got %h required 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic [31:0] d;
    s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
    @(posedge clk_i); #1;
    s_axi_awvalid = 1'b0;
    @(negedge clk_i);
    total++;
    if (s_axi_awready !== 1'b0) begin bad++; $display("FAIL aw_held: got awready=%b required 0", s_axi_awready); end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    cycles(2);
    rst_i = 1'b0;
    s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(posedge clk_i); #1;
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      total++;
      if (s_axi_bvalid !== 1'b0 || ipreg_data_o !== 32'h0) begin
        bad++;
        $display("FAIL rst_mid%0d: got bvalid=%b data=%h required 0/0", i, s_axi_bvalid, ipreg_data_o);
      end
      @(posedge clk_i); #1;
    end
    do_read(8'h08, d, resp);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_data_out: got %h required 0", d); end
    do_read(8'h10, d, resp);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_count: got %h required 0", d); end
    do_read(8'h0C, d, resp);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rst_status: got %h required 0", d); end
    total++;
    if (en_double !== 1'b0) begin bad++; $display("FAIL enable_double: got %b required 0", en_double); end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_split();
    test_completion();
    test_start_err();
    test_collisions();
    test_unmapped();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
